// File: rtl/conv_stream_sequencer_if.sv
// Control/address bundle between the conv stream sequencer and the tile's BRAM and staging blocks.
// master = sequencer (drives addresses and strobes), slave = consumer side (drives run/start/abort).
interface conv_stream_sequencer_if #(
  parameter int IMG_ADDR_WIDTH = 14,
  parameter int KER_ADDR_WIDTH = 2
);
  logic                      enable;
  logic                      start;
  logic                      abort;
  logic                      bram_en;
  logic [KER_ADDR_WIDTH-1:0] ker_addr;
  logic [IMG_ADDR_WIDTH-1:0] img_addr;
  logic                      ker_valid;
  logic                      img_valid;
  logic                      row_done;
  logic                      compute_done;
  logic                      busy;
  logic [2:0]                state_dbg;

  modport master (
    input  enable, start, abort,
    output bram_en, ker_addr, img_addr, ker_valid, img_valid,
           row_done, compute_done, busy, state_dbg
  );

  modport slave (
    output enable, start, abort,
    input  bram_en, ker_addr, img_addr, ker_valid, img_valid,
           row_done, compute_done, busy, state_dbg
  );
endinterface

// File: rtl/conv_stream_sequencer.sv
// Start/done sequenced address generator for the kernel BRAM and image banks, with
// read-data-aligned valid/row/done strobes; enable=0 freezes the whole pass in place.
module conv_stream_sequencer #(
  parameter int IMG_ADDR_WIDTH = 14,
  parameter int KER_ADDR_WIDTH = 2,
  parameter int IMG_BASE       = 1,
  parameter int IMG_WORDS      = 15,
  parameter int ROW_WORDS      = 5,
  parameter int KER_BASE       = 1,
  parameter int KER_WORDS      = 3,
  parameter int BRAM_LATENCY   = 1,
  parameter int DRAIN_CYCLES   = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  conv_stream_sequencer_if.master sif
);
  localparam int KCW         = (KER_WORDS > 1) ? $clog2(KER_WORDS) : 1;
  localparam int RCW         = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam int DRAIN_TOTAL = BRAM_LATENCY + DRAIN_CYCLES;
  localparam int DCW         = $clog2(DRAIN_TOTAL + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_KER = 3'd1,
    STREAM   = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                    state, state_nxt;
  logic [KCW-1:0]            k_cnt;
  logic [IMG_ADDR_WIDTH-1:0] i_cnt;
  logic [RCW-1:0]            r_cnt;
  logic [DCW-1:0]            d_cnt;
  logic [KER_ADDR_WIDTH-1:0] ker_addr_q, ker_addr_cur;
  logic [IMG_ADDR_WIDTH-1:0] img_addr_q, img_addr_cur;
  logic [BRAM_LATENCY-1:0]   kv_pipe, iv_pipe, rd_pipe;
  logic                      ker_issue, img_issue, row_issue, cancel;

  assign cancel       = sif.abort && (state != IDLE);
  assign ker_issue    = (state == LOAD_KER);
  assign img_issue    = (state == STREAM);
  assign row_issue    = img_issue && (r_cnt == RCW'(ROW_WORDS - 1));
  assign ker_addr_cur = KER_ADDR_WIDTH'(KER_BASE) + KER_ADDR_WIDTH'(k_cnt);
  assign img_addr_cur = IMG_ADDR_WIDTH'(IMG_BASE) + i_cnt;

  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (sif.start && !sif.abort) state_nxt = LOAD_KER;
        LOAD_KER: if (k_cnt == KCW'(KER_WORDS - 1)) state_nxt = STREAM;
        STREAM:   if (i_cnt == IMG_ADDR_WIDTH'(IMG_WORDS - 1)) state_nxt = DRAIN;
        DRAIN:    if (d_cnt == DCW'(DRAIN_TOTAL - 1)) state_nxt = DONE;
        DONE:     state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Nothing advances on paused cycles, so the pass resumes exactly where it stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      k_cnt      <= '0;
      i_cnt      <= '0;
      r_cnt      <= '0;
      d_cnt      <= '0;
      ker_addr_q <= '0;
      img_addr_q <= '0;
      kv_pipe    <= '0;
      iv_pipe    <= '0;
      rd_pipe    <= '0;
    end else if (sif.enable) begin
      state <= state_nxt;
      if (cancel) begin
        kv_pipe <= '0;
        iv_pipe <= '0;
        rd_pipe <= '0;
      end else begin
        kv_pipe <= BRAM_LATENCY'({kv_pipe, ker_issue});
        iv_pipe <= BRAM_LATENCY'({iv_pipe, img_issue});
        rd_pipe <= BRAM_LATENCY'({rd_pipe, row_issue});
      end
      if (state_nxt == IDLE) begin
        k_cnt      <= '0;
        i_cnt      <= '0;
        r_cnt      <= '0;
        d_cnt      <= '0;
        ker_addr_q <= '0;
        img_addr_q <= '0;
      end else begin
        if (ker_issue) begin
          k_cnt      <= k_cnt + KCW'(1);
          ker_addr_q <= ker_addr_cur;
        end
        if (img_issue) begin
          i_cnt      <= i_cnt + IMG_ADDR_WIDTH'(1);
          img_addr_q <= img_addr_cur;
          r_cnt      <= row_issue ? '0 : r_cnt + RCW'(1);
        end
        if (state == DRAIN) d_cnt <= d_cnt + DCW'(1);
      end
    end
  end

  assign sif.bram_en      = sif.enable && (ker_issue || img_issue);
  assign sif.ker_addr     = ker_issue ? ker_addr_cur : ker_addr_q;
  assign sif.img_addr     = img_issue ? img_addr_cur : img_addr_q;
  assign sif.ker_valid    = sif.enable && kv_pipe[BRAM_LATENCY-1];
  assign sif.img_valid    = sif.enable && iv_pipe[BRAM_LATENCY-1];
  assign sif.row_done     = sif.enable && rd_pipe[BRAM_LATENCY-1];
  // A same-cycle abort suppresses the done pulse as well.
  assign sif.compute_done = sif.enable && (state == DONE) && !sif.abort;
  assign sif.busy         = (state != IDLE);
  assign sif.state_dbg    = state;
endmodule
